// File: rtl/uart_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_pkg : shared UART frame format, FSM encoding and helpers         |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam int DATA_BITS  = 8;
   localparam int STOP_BITS  = 1;
   localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

   // Clock cycles occupied by one complete frame on the line.
   function automatic int frame_cycles(input int clk_per_bit);
      return FRAME_BITS * clk_per_bit;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tx_fifo : synchronous FIFO with full/empty flags and wrap-bit pointers|
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   // The extra pointer MSB distinguishes a wrapped (full) FIFO from an empty one.
   always_comb begin
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      empty    = (wr_ptr_q == rd_ptr_q);
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      pop_data = mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_tx : buffered 8N1 serial transmitter with valid/ready input      |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_PER_BIT = 100,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       valid,
   output logic       ready,
   output logic       serial_line,
   output logic       busy
);

   localparam int                CNT_W    = $clog2(CLK_PER_BIT);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [2:0]        LAST_BIT = 3'(DATA_BITS - 1);

   uart_state_e               state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [2:0]                bit_q, bit_d;
   logic [DATA_BITS-1:0]      shift_q, shift_d;
   logic                      line_q, line_d;

   logic                      fifo_push;
   logic                      fifo_pop;
   logic [DATA_BITS-1:0]      fifo_rdata;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic                      bit_end;

   tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (data_in),
      .pop       (fifo_pop),
      .pop_data  (fifo_rdata),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign ready       = !fifo_full;
   assign fifo_push   = valid && !fifo_full;
   assign busy        = (state_q != IDLE) || !fifo_empty;
   assign serial_line = line_q;
   assign bit_end     = (cnt_q == CNT_LAST);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;
      line_d   = 1'b1;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_rdata;
               state_d  = START;
            end
         end
         START: begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_ONE;
            if (bit_end) begin
               bit_d   = 3'd0;
               state_d = DATA;
            end
         end
         DATA: begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_ONE;
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == LAST_BIT) begin
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         STOP: begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_ONE;
            // A queued byte chains straight into the next start bit.
            if (bit_end) begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_rdata;
                  state_d  = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Line level is decoded from the next state so the register leads the FSM.
      case (state_d)
         START:   line_d = 1'b0;
         DATA:    line_d = shift_d[0];
         default: line_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         shift_q <= '0;
         line_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         line_q  <= line_d;
      end
   end

endmodule
`default_nettype wire
